// File: rtl/measurement_frame_packer.sv
// Serialises single-round syndrome words into framed bytes on an 8-bit valid/ready stream:
// one START byte after reset, then per frame a header byte followed by zero-padded round bytes.
module measurement_frame_packer #(
  parameter int unsigned GRID_WIDTH_X            = 4,
  parameter int unsigned GRID_WIDTH_Z            = 1,
  parameter int unsigned MEASUREMENT_ROUNDS      = 2,
  parameter logic [7:0]  START_DECODING_MSG      = 8'h01,
  parameter logic [7:0]  MEASUREMENT_DATA_HEADER = 8'h02
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0] round_data,
  input  logic                                 round_valid,
  output logic                                 round_ready,
  output logic [7:0]                           output_data,
  output logic                                 output_valid,
  input  logic                                 output_ready,
  output logic                                 busy,
  output logic [15:0]                          frame_count
);

  localparam int unsigned PU_PER_ROUND    = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int unsigned BYTES_PER_ROUND = (PU_PER_ROUND + 7) >> 3;
  localparam int unsigned PAD_W           = BYTES_PER_ROUND * 8;
  localparam int unsigned BW = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;
  localparam int unsigned RW = (MEASUREMENT_ROUNDS > 1) ? $clog2(MEASUREMENT_ROUNDS) : 1;
  localparam logic [BW-1:0] LAST_BYTE  = BW'(BYTES_PER_ROUND - 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(MEASUREMENT_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_START,
    S_IDLE,
    S_HEADER,
    S_PAYLOAD
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_out_valid;
  logic [7:0]              r_out_data;
  logic                    r_full;
  logic [PU_PER_ROUND-1:0] r_buf;
  logic [BW-1:0]           r_byte_idx;
  logic [RW-1:0]           r_rnd_idx;
  logic [15:0]             r_frame_cnt;

  logic                    w_xfer;
  logic                    w_last_byte;
  logic                    w_last_round;
  logic                    w_round_done;
  logic                    w_frame_done;
  logic                    w_round_ready;
  logic                    w_accept;
  logic                    w_full_nxt;
  logic [BW-1:0]           w_byte_nxt;
  logic [RW-1:0]           w_rnd_nxt;
  logic                    w_valid_nxt;
  logic [7:0]              w_data_nxt;
  logic [PAD_W-1:0]        w_buf_pad;
  logic [PAD_W-1:0]        w_new_pad;

  function automatic logic [7:0] pick_byte(input logic [PAD_W-1:0] v, input logic [BW-1:0] idx);
    logic [7:0] b;
    b = '0;
    for (int unsigned k = 0; k < BYTES_PER_ROUND; k++) begin
      if (idx == BW'(k)) b = v[8*k +: 8];
    end
    return b;
  endfunction

  always_comb begin
    w_buf_pad                   = '0;
    w_buf_pad[PU_PER_ROUND-1:0] = r_buf;
    w_new_pad                   = '0;
    w_new_pad[PU_PER_ROUND-1:0] = round_data;
  end

  always_comb begin
    w_xfer        = r_out_valid & output_ready;
    w_last_byte   = (r_byte_idx == LAST_BYTE);
    w_last_round  = (r_rnd_idx == LAST_ROUND);
    w_round_done  = (r_state == S_PAYLOAD) & w_xfer & w_last_byte;
    w_frame_done  = w_round_done & w_last_round;
    // The buffer may reload on the same edge its last byte leaves, so ready looks ahead one transfer.
    w_round_ready = (r_state != S_START) & (~r_full | w_round_done);
    w_accept      = round_valid & w_round_ready;
    w_full_nxt    = w_accept | (r_full & ~w_round_done);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_START;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_full      <= 1'b0;
      r_buf       <= '0;
      r_byte_idx  <= '0;
      r_rnd_idx   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_data  <= w_data_nxt;
      r_full      <= w_full_nxt;
      r_byte_idx  <= w_byte_nxt;
      r_rnd_idx   <= w_rnd_nxt;
      if (w_accept)     r_buf       <= round_data;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_byte_nxt  = r_byte_idx;
    w_rnd_nxt   = r_rnd_idx;
    case (r_state)
      S_START:  if (w_xfer) w_state_nxt = S_IDLE;
      S_IDLE:   if (r_full) w_state_nxt = S_HEADER;
      S_HEADER: begin
        if (w_xfer) begin
          w_state_nxt = S_PAYLOAD;
          w_byte_nxt  = '0;
          w_rnd_nxt   = '0;
        end
      end
      S_PAYLOAD: begin
        if (w_xfer) begin
          if (w_last_byte) begin
            w_byte_nxt = '0;
            if (w_last_round) begin
              w_rnd_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_rnd_nxt = r_rnd_idx + 1'b1;
            end
          end else begin
            w_byte_nxt = r_byte_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_START;
    endcase
  end

  // Next contents of the registered output byte; holds while a valid byte waits for ready.
  always_comb begin
    w_valid_nxt = r_out_valid;
    w_data_nxt  = r_out_data;
    case (r_state)
      S_START: begin
        if (w_xfer) begin
          w_valid_nxt = 1'b0;
        end else begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = START_DECODING_MSG;
        end
      end
      S_IDLE: begin
        if (r_full) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = MEASUREMENT_DATA_HEADER;
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      S_HEADER: begin
        if (w_xfer) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = pick_byte(w_buf_pad, w_byte_nxt);
        end
      end
      S_PAYLOAD: begin
        if (w_xfer) begin
          if (!w_last_byte) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = pick_byte(w_buf_pad, w_byte_nxt);
          end else if (w_last_round) begin
            w_valid_nxt = 1'b0;
          end else if (w_accept) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = pick_byte(w_new_pad, '0);
          end else begin
            w_valid_nxt = 1'b0;
          end
        end else if (!r_out_valid && r_full) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = pick_byte(w_buf_pad, r_byte_idx);
        end
      end
      default: w_valid_nxt = 1'b0;
    endcase
  end

  always_comb begin
    round_ready  = w_round_ready;
    output_valid = r_out_valid;
    output_data  = r_out_data;
    busy         = (r_state == S_HEADER) || (r_state == S_PAYLOAD);
    frame_count  = r_frame_cnt;
  end

endmodule

// File: tb/tb_measurement_frame_packer.sv
// Directed bench: default 4-bit rounds plus a 12-bit instance for multi-byte rounds and padding.
module tb_measurement_frame_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  a_rd;
  logic        a_rv, a_rr, a_ov, a_or, a_busy;
  logic [7:0]  a_od;
  logic [15:0] a_fc;
  logic [11:0] b_rd;
  logic        b_rv, b_rr, b_ov, b_or, b_busy;
  logic [7:0]  b_od;
  logic [15:0] b_fc;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         sa[$];

  measurement_frame_packer #(
    .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .MEASUREMENT_ROUNDS(2),
    .START_DECODING_MSG(8'h01), .MEASUREMENT_DATA_HEADER(8'h02)
  ) u_a (
    .clk(clk), .reset(reset), .round_data(a_rd), .round_valid(a_rv), .round_ready(a_rr),
    .output_data(a_od), .output_valid(a_ov), .output_ready(a_or), .busy(a_busy),
    .frame_count(a_fc)
  );

  measurement_frame_packer #(
    .GRID_WIDTH_X(6), .GRID_WIDTH_Z(2), .MEASUREMENT_ROUNDS(2),
    .START_DECODING_MSG(8'h01), .MEASUREMENT_DATA_HEADER(8'h02)
  ) u_b (
    .clk(clk), .reset(reset), .round_data(b_rd), .round_valid(b_rv), .round_ready(b_rr),
    .output_data(b_od), .output_valid(b_ov), .output_ready(b_or), .busy(b_busy),
    .frame_count(b_fc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && a_ov && a_or) begin
      qa.push_back(a_od);
      sa.push_back(cyc);
    end
    if (reset && b_ov && b_or) qb.push_back(b_od);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_round(input bit sel_b, input logic [11:0] d);
    bit got;
    got = 1'b0;
    if (sel_b) begin b_rd = d; b_rv = 1'b1; end
    else begin a_rd = d[3:0]; a_rv = 1'b1; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sel_b ? b_rr : a_rr) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (sel_b) b_rv = 1'b0; else a_rv = 1'b0;
    chk("round_accept", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    a_rd = '0; a_rv = 1'b0; a_or = 1'b0;
    b_rd = '0; b_rv = 1'b0; b_or = 1'b0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", {31'd0, a_ov}, 32'd0);
    chk("rst_data", {24'd0, a_od}, 32'h00);
    chk("rst_rready", {31'd0, a_rr}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_fcount", {16'd0, a_fc}, 32'd0);

    // START byte only
    reset = 1'b1; a_or = 1'b1; b_or = 1'b1;
    repeat (6) @(posedge clk); #2;
    chk("start_count", qa.size(), 32'd1);
    chk("start_byte", {24'd0, qa[0]}, 32'h01);
    chk("start_valid_after", {31'd0, a_ov}, 32'd0);
    chk("start_rready_after", {31'd0, a_rr}, 32'd1);
    chk("b_start_count", qb.size(), 32'd1);
    chk("b_start_byte", {24'd0, qb[0]}, 32'h01);
    qa.delete(); sa.delete(); qb.delete();

    // 12-bit rounds: two bytes each, upper nibble padded
    send_round(1'b1, 12'hA5C);
    send_round(1'b1, 12'h3FF);
    repeat (4) @(posedge clk); #2;
    chk("b_frame_len", qb.size(), 32'd5);
    chk("b_hdr", {24'd0, qb[0]}, 32'h02);
    chk("b_p0", {24'd0, qb[1]}, 32'h5C);
    chk("b_p1", {24'd0, qb[2]}, 32'h0A);
    chk("b_p2", {24'd0, qb[3]}, 32'hFF);
    chk("b_p3", {24'd0, qb[4]}, 32'h03);
    chk("b_fcount", {16'd0, b_fc}, 32'd1);

    // Basic frame
    send_round(1'b0, 12'h00B);
    send_round(1'b0, 12'h004);
    repeat (3) @(posedge clk); #2;
    chk("f1_len", qa.size(), 32'd3);
    chk("f1_hdr", {24'd0, qa[0]}, 32'h02);
    chk("f1_p0", {24'd0, qa[1]}, 32'h0B);
    chk("f1_p1", {24'd0, qa[2]}, 32'h04);
    chk("f1_fcount", {16'd0, a_fc}, 32'd1);
    chk("f1_busy_after", {31'd0, a_busy}, 32'd0);
    qa.delete(); sa.delete();

    // Backpressure mid-payload
    a_or = 1'b0;
    send_round(1'b0, 12'h00C);
    repeat (2) @(posedge clk); #1;
    chk("stall_hdr_wait", {24'd0, a_od}, 32'h02);
    a_or = 1'b1;
    @(posedge clk); #1;
    a_or = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold_data", {24'd0, a_od}, 32'h0C);
      chk("stall_hold_valid", {31'd0, a_ov}, 32'd1);
    end
    @(posedge clk); #1;
    a_or = 1'b1;
    send_round(1'b0, 12'h003);
    repeat (4) @(posedge clk); #2;
    chk("f2_len", qa.size(), 32'd3);
    chk("f2_hdr", {24'd0, qa[0]}, 32'h02);
    chk("f2_p0", {24'd0, qa[1]}, 32'h0C);
    chk("f2_p1", {24'd0, qa[2]}, 32'h03);
    chk("f2_fcount", {16'd0, a_fc}, 32'd2);

    // Streaming after a fresh reset: 6 rounds, 3 frames, single idle between frames
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) @(posedge clk); #2;
    qa.delete(); sa.delete();
    send_round(1'b0, 12'h009);
    send_round(1'b0, 12'h006);
    send_round(1'b0, 12'h00F);
    send_round(1'b0, 12'h000);
    send_round(1'b0, 12'h005);
    send_round(1'b0, 12'h00A);
    repeat (6) @(posedge clk); #2;
    chk("str_len", qa.size(), 32'd9);
    chk("str_b0", {24'd0, qa[0]}, 32'h02);
    chk("str_b1", {24'd0, qa[1]}, 32'h09);
    chk("str_b2", {24'd0, qa[2]}, 32'h06);
    chk("str_b3", {24'd0, qa[3]}, 32'h02);
    chk("str_b4", {24'd0, qa[4]}, 32'h0F);
    chk("str_b5", {24'd0, qa[5]}, 32'h00);
    chk("str_b6", {24'd0, qa[6]}, 32'h02);
    chk("str_b7", {24'd0, qa[7]}, 32'h05);
    chk("str_b8", {24'd0, qa[8]}, 32'h0A);
    chk("str_span_cycles", sa[8] - sa[0], 32'd10);
    chk("str_fcount", {16'd0, a_fc}, 32'd3);

    // Asynchronous reset while the second payload byte waits
    a_or = 1'b0;
    send_round(1'b0, 12'h007);
    repeat (2) @(posedge clk); #1;
    a_or = 1'b1;
    @(posedge clk); #1;
    send_round(1'b0, 12'h00E);
    a_or = 1'b0;
    #3;
    chk("mid_valid", {31'd0, a_ov}, 32'd1);
    chk("mid_data", {24'd0, a_od}, 32'h0E);
    chk("mid_busy", {31'd0, a_busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, a_ov}, 32'd0);
    chk("arst_data", {24'd0, a_od}, 32'h00);
    chk("arst_busy", {31'd0, a_busy}, 32'd0);
    chk("arst_rready", {31'd0, a_rr}, 32'd0);
    chk("arst_fcount", {16'd0, a_fc}, 32'd0);
    qa.delete(); sa.delete();
    #3;
    @(posedge clk); #1;
    reset = 1'b1; a_or = 1'b1;
    repeat (6) @(posedge clk); #2;
    chk("restart_count", qa.size(), 32'd1);
    chk("restart_byte", {24'd0, qa[0]}, 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
